dcache_mem_stage: RTL and testbench
===================================

# dcache_mem_stage

Parametrised MEM pipeline stage with a direct-mapped, write-through data cache and a blocking miss FSM, sitting between the EX and WB stages of the RISC-V pipeline. Successor to the fixed 4-line MEM stage: adds configurable line count and memory latency, byte/halfword/word loads and stores, write-update on store hits, and a stall output that freezes the upstream pipeline during a load miss.

## Interface
- LINES, 4: cache lines, power of two, ≥2
- MEM_WORDS, 16384: backing data memory depth in 32-bit words, power of two
- MISS_LAT, 2: backing-memory read latency in cycles, ≥1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- EX_valid  in  1  EX slot holds a real instruction
- EX_instr  in  32  instruction word, passed through
- EX_rd  in  5  destination register index
- EX_opcode  in  7  opcode; 0000011 load, 0100011 store, other = ALU pass
- EX_funct3  in  3  access size/sign for loads/stores
- EX_regwrite  in  1  write-back enable, passed through
- EX_alu_result  in  32  byte address (load/store) or ALU result
- EX_r2  in  32  store data
- stall  out  1  EX/ID/IF must hold when high (combinational)
- MEM_valid  out  1  MEM outputs hold a completed instruction
- MEM_instr / MEM_rd / MEM_opcode / MEM_regwrite  out  32/5/7/1  registered pass-through
- MEM_data  out  32  load data (extended) or ALU result; 0 for stores

## Operation
- Address split: word = EX_alu_result[31:2]; index = word[log2(LINES)-1:0]; tag = remaining upper bits; memory index = word mod MEM_WORDS.
- States: IDLE, MISS. IDLE: load with valid tag match → hit; load mismatch/invalid → stall=1, go MISS, cnt ← MISS_LAT-1. MISS: stall=1; cnt decrements; at cnt==0 fill line (data, tag, valid=1), register result, go IDLE.
- stall = EX_valid & load & miss in IDLE, or state==MISS.
- Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane from addr[1:0], halfword from addr[1] (addr[0] ignored), LW ignores addr[1:0]; sign/zero extend to 32. Other funct3 → treat as LW.
- Stores: SB 000, SH 001, SW 010; merge bytes into memory word (write-through). On tag hit, merge same bytes into cache line (write-update); on miss, no allocate, cache unchanged. Never stalls. MEM_data ← 0.
- Other opcodes: MEM_data ← EX_alu_result.
- EX_valid=0: no memory/cache access; MEM_valid ← 0.
- While stall is high, MEM_valid ← 0 (bubble) except on the completing MISS cycle.

## Timing
- Reset (async): all outputs 0, state IDLE, all valid bits 0, stall 0; memory contents untouched. Reset during MISS aborts the fill (no line written).
- Hit/store/ALU: 1 cycle; outputs at next edge.
- Load miss: stall high 1+MISS_LAT cycles; result and MEM_valid=1 at the edge ending the last stall cycle; next instruction accepted in the following cycle.
- Store and load on consecutive cycles, same address: load sees stored data (hit path reads updated line; miss path reads updated memory).

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count and miss_count (32-bit each, reset 0, wrap on overflow), incremented once per load hit (IDLE) and once per load miss (at detection). Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package dcache_pkg: OP_LOAD, OP_STORE, funct3 constants (F3_B/H/W/BU/HU), state encoding, byte-lane extract/merge functions.
- One sub-module: dcache_array (valid/tag/data arrays, async read, one write port with byte enables, synchronous valid clear on reset).

## Test plan
- Reset, then LW addr 0x10 (memory 0xDEADBEEF) → stall 3 cycles (MISS_LAT=2), MEM_data=0xDEADBEEF, MEM_valid=1; repeat LW 0x10 → 1-cycle hit, same data.
- SW 0xCAFEBABE to 0x10 after fill, then LW 0x10 → hit, 0xCAFEBABE, no stall.
- SB 0x80 at 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → sign-extended upper half.
- Conflicting tags: LW 0x00 then LW 0x10 (LINES=4, same index) → both miss; LW 0x00 again → miss.
- Assert reset at MISS cycle 1 → outputs 0, stall 0 immediately; subsequent LW same address → miss.
- With DCACHE_STATS_EN: 2 misses + 3 hits → miss_count=2, hit_count=3.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and byte-lane helpers for the MEM-stage data cache.
package dcache_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        regwrite;
    logic [31:0] addr;
  } req_t;

  // Halfword lane comes from off[1] only; unknown funct3 reads as a full word.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'b0, b};
      F3_HU:   return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] r2, input logic [2:0] f3);
    case (f3)
      F3_B:    return {4{r2[7:0]}};
      F3_H:    return {2{r2[15:0]}};
      default: return r2;
    endcase
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped valid/tag/data store: async read, one byte-enabled write port.
module dcache_array #(
  parameter int LINES = 4,
  parameter int IW    = 2,
  parameter int TW    = 28
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be
);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [31:0]      data [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_mem_stage.sv
// MEM stage: direct-mapped write-through cache, blocking load-miss FSM.
// Define DCACHE_STATS_EN to add hit_count/miss_count outputs.
module dcache_mem_stage
  import dcache_pkg::*;
#(
  parameter int LINES     = 4,
  parameter int MEM_WORDS = 16384,
  parameter int MISS_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_valid,
  input  logic [31:0] EX_instr,
  input  logic [4:0]  EX_rd,
  input  logic [6:0]  EX_opcode,
  input  logic [2:0]  EX_funct3,
  input  logic        EX_regwrite,
  input  logic [31:0] EX_alu_result,
  input  logic [31:0] EX_r2,
  output logic        stall,
  output logic        MEM_valid,
  output logic [31:0] MEM_instr,
  output logic [4:0]  MEM_rd,
  output logic [6:0]  MEM_opcode,
  output logic        MEM_regwrite,
  output logic [31:0] MEM_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;
  localparam int MW = $clog2(MEM_WORDS);
  localparam int CW = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  req_t          req;
  logic [31:0]   mem [MEM_WORDS];

  logic          is_load, is_store, access, hit, store_go, fill;
  logic          rd_valid, we;
  logic [IW-1:0] ex_idx, wr_idx;
  logic [TW-1:0] ex_tag, rd_tag, wr_tag;
  logic [MW-1:0] ex_midx, req_midx;
  logic [31:0]   rd_data, fill_word, st_data, wr_data;
  logic [3:0]    st_be, wr_be;

  assign is_load   = EX_opcode == OP_LOAD;
  assign is_store  = EX_opcode == OP_STORE;
  assign ex_idx    = EX_alu_result[IW+1:2];
  assign ex_tag    = EX_alu_result[31:IW+2];
  assign ex_midx   = EX_alu_result[MW+1:2];
  assign req_midx  = req.addr[MW+1:2];
  assign fill_word = mem[req_midx];
  assign st_be     = store_be(EX_funct3, EX_alu_result[1:0]);
  assign st_data   = store_data(EX_r2, EX_funct3);

  // Reset masks every access so an aborted fill never lands and stall drops at once.
  assign access   = !reset && state == S_IDLE && EX_valid;
  assign hit      = rd_valid && rd_tag == ex_tag;
  assign store_go = access && is_store;
  assign fill     = !reset && state == S_MISS && cnt == '0;
  assign stall    = (access && is_load && !hit) || (!reset && state == S_MISS);

  always_comb begin
    we      = 1'b0;
    wr_idx  = ex_idx;
    wr_tag  = ex_tag;
    wr_data = st_data;
    wr_be   = st_be;
    if (fill) begin
      we      = 1'b1;
      wr_idx  = req.addr[IW+1:2];
      wr_tag  = req.addr[31:IW+2];
      wr_data = fill_word;
      wr_be   = 4'hF;
    end else if (store_go && hit) begin
      we = 1'b1;
    end
  end

  dcache_array #(.LINES(LINES), .IW(IW), .TW(TW)) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (ex_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .we      (we),
    .wr_idx  (wr_idx),
    .wr_tag  (wr_tag),
    .wr_data (wr_data),
    .wr_be   (wr_be)
  );

  // Backing memory is write-through target and is never cleared.
  always_ff @(posedge clk) begin
    if (store_go)
      for (int b = 0; b < 4; b++)
        if (st_be[b]) mem[ex_midx][8*b +: 8] <= st_data[8*b +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      req          <= '0;
      MEM_valid    <= 1'b0;
      MEM_instr    <= '0;
      MEM_rd       <= '0;
      MEM_opcode   <= '0;
      MEM_regwrite <= 1'b0;
      MEM_data     <= '0;
`ifdef DCACHE_STATS_EN
      hit_count    <= '0;
      miss_count   <= '0;
`endif
    end else begin
      MEM_valid <= 1'b0;
      case (state)
        S_IDLE: if (EX_valid) begin
          if (is_load && !hit) begin
            state        <= S_MISS;
            cnt          <= CW'(MISS_LAT - 1);
            req.instr    <= EX_instr;
            req.rd       <= EX_rd;
            req.opcode   <= EX_opcode;
            req.funct3   <= EX_funct3;
            req.regwrite <= EX_regwrite;
            req.addr     <= EX_alu_result;
`ifdef DCACHE_STATS_EN
            miss_count   <= miss_count + 32'd1;
`endif
          end else begin
            MEM_valid    <= 1'b1;
            MEM_instr    <= EX_instr;
            MEM_rd       <= EX_rd;
            MEM_opcode   <= EX_opcode;
            MEM_regwrite <= EX_regwrite;
            MEM_data     <= is_load  ? load_extract(rd_data, EX_funct3, EX_alu_result[1:0]) :
                            is_store ? 32'd0 : EX_alu_result;
`ifdef DCACHE_STATS_EN
            if (is_load) hit_count <= hit_count + 32'd1;
`endif
          end
        end
        S_MISS: begin
          if (cnt == '0) begin
            state        <= S_IDLE;
            MEM_valid    <= 1'b1;
            MEM_instr    <= req.instr;
            MEM_rd       <= req.rd;
            MEM_opcode   <= req.opcode;
            MEM_regwrite <= req.regwrite;
            MEM_data     <= load_extract(fill_word, req.funct3, req.addr[1:0]);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Randomised bench for dcache_mem_stage against a line/memory reference model.
module tb_dcache_mem_stage;

  localparam int LINES     = 4;
  localparam int MEM_WORDS = 16384;
  localparam int MISS_LAT  = 2;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0, reset = 1'b0;
  logic        EX_valid = 1'b0, EX_regwrite = 1'b0;
  logic [31:0] EX_instr = '0, EX_alu_result = '0, EX_r2 = '0;
  logic [4:0]  EX_rd = '0;
  logic [6:0]  EX_opcode = '0;
  logic [2:0]  EX_funct3 = '0;
  logic        stall, MEM_valid, MEM_regwrite;
  logic [31:0] MEM_instr, MEM_data;
  logic [4:0]  MEM_rd;
  logic [6:0]  MEM_opcode;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0, errors = 0;
  int hcnt = 0, mcnt = 0;
  int          line_word [LINES];   // word address held by each line, -1 = empty
  logic [31:0] line_data [LINES];
  logic [31:0] mmem [int];

  dcache_mem_stage #(.LINES(LINES), .MEM_WORDS(MEM_WORDS), .MISS_LAT(MISS_LAT)) dut (
    .clk(clk), .reset(reset), .EX_valid(EX_valid), .EX_instr(EX_instr), .EX_rd(EX_rd),
    .EX_opcode(EX_opcode), .EX_funct3(EX_funct3), .EX_regwrite(EX_regwrite),
    .EX_alu_result(EX_alu_result), .EX_r2(EX_r2), .stall(stall), .MEM_valid(MEM_valid),
    .MEM_instr(MEM_instr), .MEM_rd(MEM_rd), .MEM_opcode(MEM_opcode),
    .MEM_regwrite(MEM_regwrite), .MEM_data(MEM_data)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input int off);
    int v;
    case (f3)
      3'd0, 3'd4: begin
        v = int'((word >> (8 * off)) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v -= 256;
      end
      3'd1, 3'd5: begin
        v = int'((word >> (16 * (off / 2))) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
      end
      default: v = int'(word);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] r2,
                                            input logic [2:0] f3, input int off);
    logic [31:0] m, d;
    case (f3)
      3'd0:    begin m = 32'hFF << (8 * off);          d = (r2 & 32'hFF) << (8 * off); end
      3'd1:    begin m = 32'hFFFF << (16 * (off / 2)); d = (r2 & 32'hFFFF) << (16 * (off / 2)); end
      default: begin m = 32'hFFFF_FFFF;                d = r2; end
    endcase
    return (old & ~m) | d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) line_word[i] = -1;
    hcnt = 0;
    mcnt = 0;
  endtask

  // Issues one instruction at posedge+1 and waits for its completion.
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] r2, input string nm);
    int w, idx, mi, off, exp_st, cyc, st;
    logic [31:0] exp_d, old;
    logic [4:0] rd;
    logic rw;
    w = int'(addr >> 2); idx = w % LINES; mi = w % MEM_WORDS; off = int'(addr & 32'd3);
    rd = 5'($urandom_range(0, 31));
    rw = 1'($urandom_range(0, 1));
    exp_st = 0;
    exp_d = addr;
    if (op == LD) begin
      if (line_word[idx] == w) begin
        hcnt++;
      end else begin
        mcnt++;
        exp_st = 1 + MISS_LAT;
        line_word[idx] = w;
        line_data[idx] = mmem[mi];
      end
      exp_d = ref_load(line_data[idx], f3, off);
    end else if (op == ST) begin
      exp_d = 32'd0;
      old = mmem.exists(mi) ? mmem[mi] : 32'd0;
      mmem[mi] = ref_store(old, r2, f3, off);
      if (line_word[idx] == w) line_data[idx] = ref_store(line_data[idx], r2, f3, off);
    end
    EX_valid = 1'b1; EX_opcode = op; EX_funct3 = f3; EX_alu_result = addr; EX_r2 = r2;
    EX_rd = rd; EX_regwrite = rw; EX_instr = $urandom;
    cyc = 0;
    st = 0;
    while (cyc < 40) begin
      #1;
      if (stall) st++;
      @(posedge clk);
      #1;
      cyc++;
      if (MEM_valid) break;
    end
    EX_valid = 1'b0;
    checks++;
    if (MEM_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b after %0d cycles, want 1", nm, MEM_valid, cyc);
    end
    checks++;
    if (st != exp_st) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, st, exp_st);
    end
    checks++;
    if (MEM_data !== exp_d) begin
      errors++;
      $display("FAIL %s data @%h f3=%0d: got %h want %h", nm, addr, f3, MEM_data, exp_d);
    end
    checks++;
    if (MEM_rd !== rd || MEM_regwrite !== rw || MEM_opcode !== op) begin
      errors++;
      $display("FAIL %s passthru: got rd=%0d rw=%b op=%b want rd=%0d rw=%b op=%b",
               nm, MEM_rd, MEM_regwrite, MEM_opcode, rd, rw, op);
    end
  endtask

  task automatic test_reset();
    EX_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({MEM_valid, MEM_data, MEM_rd, MEM_instr, MEM_opcode, MEM_regwrite, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h rd=%0d instr=%h stall=%b want all 0",
               MEM_valid, MEM_data, MEM_rd, MEM_instr, stall);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_miss_hit();
    do_op(LD, 3'd2, 32'h10, 0, "lw_miss_0x10");
    do_op(LD, 3'd2, 32'h10, 0, "lw_hit_0x10");
  endtask

  task automatic test_store_hit();
    do_op(ST, 3'd2, 32'h10, 32'hCAFEBABE, "sw_hit_0x10");
    do_op(LD, 3'd2, 32'h10, 0, "lw_after_sw");
  endtask

  task automatic test_bytes();
    do_op(ST, 3'd0, 32'h13, 32'h0000_0080, "sb_0x13");
    do_op(LD, 3'd0, 32'h13, 0, "lb_0x13");
    do_op(LD, 3'd4, 32'h13, 0, "lbu_0x13");
    do_op(LD, 3'd1, 32'h12, 0, "lh_0x12");
    do_op(LD, 3'd1, 32'h13, 0, "lh_0x13");
    do_op(LD, 3'd5, 32'h10, 0, "lhu_0x10");
  endtask

  task automatic test_conflict();
    do_op(LD, 3'd2, 32'h00, 0, "conf_lw_0x00");
    do_op(LD, 3'd2, 32'h10, 0, "conf_lw_0x10");
    do_op(LD, 3'd2, 32'h00, 0, "conf_lw_0x00_again");
  endtask

  task automatic test_reset_miss();
    EX_valid = 1'b1; EX_opcode = LD; EX_funct3 = 3'd2; EX_alu_result = 32'h10; EX_rd = 5'd3;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_miss_detect stall: got %b want 1", stall);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || MEM_valid !== 1'b0 || MEM_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_in_miss: got stall=%b valid=%b data=%h want 0 0 0", stall, MEM_valid, MEM_data);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    EX_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    do_op(LD, 3'd2, 32'h10, 0, "lw_after_abort");
  endtask

  task automatic test_random();
    int words [8];
    int k;
    logic [31:0] a;
    words = '{0, 1, 2, 3, 4, 5, 8, MEM_WORDS + 1};
    foreach (words[i]) do_op(ST, 3'd2, 32'(words[i] * 4), $urandom, "rnd_init");
    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(0, 9);
      a = 32'(words[$urandom_range(0, 7)] * 4) + 32'($urandom_range(0, 3));
      if (k <= 4) do_op(LD, 3'($urandom_range(0, 7)), a, 0, "rnd_load");
      else if (k <= 7) do_op(ST, 3'($urandom_range(0, 2)), a, $urandom, "rnd_store");
      else if (k == 8) do_op(ALU, 3'($urandom_range(0, 7)), $urandom, $urandom, "rnd_alu");
      else begin
        EX_valid = 1'b0;
        EX_opcode = LD;
        EX_alu_result = a;
        #1;
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL bubble_stall: got %b want 0", stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (MEM_valid !== 1'b0) begin
          errors++;
          $display("FAIL bubble_valid: got %b want 0", MEM_valid);
        end
      end
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    test_reset();
    do_op(LD, 3'd2, 32'h00, 0, "st_miss0");
    do_op(LD, 3'd2, 32'h00, 0, "st_hit0");
    do_op(LD, 3'd2, 32'h04, 0, "st_miss1");
    do_op(LD, 3'd2, 32'h04, 0, "st_hit1");
    do_op(LD, 3'd2, 32'h00, 0, "st_hit2");
    checks++;
    if (hit_count !== 32'd3 || miss_count !== 32'd2 || hit_count !== 32'(hcnt)) begin
      errors++;
      $display("FAIL stats: got hit=%0d miss=%0d want hit=3 miss=2", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    #1;
    model_reset();
    test_reset();
    do_op(ST, 3'd2, 32'h10, 32'hDEADBEEF, "preload_0x10");
    do_op(ST, 3'd2, 32'h00, 32'h1122_3344, "preload_0x00");
    test_reset();
    test_miss_hit();
    test_store_hit();
    test_bytes();
    test_conflict();
    test_reset_miss();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
